sram_port_master: RTL and testbench

SRAM_PORT_MASTER -- requirements
Module: sram_port_master

---
 rtl/sram_pkg.sv | 14 +
 rtl/single_port_sync_ram.sv | 31 +++
 rtl/sram_port_master.sv | 110 +++++++++++
 tb/tb_sram_port_master.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared FSM state type and default geometry for the SRAM port master.
package sram_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } sram_state_e;

endpackage

// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM with a shared tri-state data bus; read word is
// registered on the edge closing the address cycle and driven while cs&oe&!we.
module single_port_sync_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_q;
  logic                  w_rd_en;

  assign w_rd_en = cs && oe && !we;

  always_ff @(posedge clk) begin
    if (cs && we) begin
      r_mem[addr] <= data;
    end else if (w_rd_en) begin
      r_q <= r_mem[addr];
    end
  end

  assign data = w_rd_en ? r_q : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/sram_port_master.sv
// Request/response front end that sequences one-cycle writes and two-cycle
// reads onto a synchronous SRAM with a shared bidirectional data bus.
module sram_port_master
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  sram_state_e           r_state;
  logic                  r_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_cs;
  logic                  r_we;
  logic                  r_oe;
  logic                  r_drive;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_addr      <= '0;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_oe        <= 1'b0;
      r_drive     <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // r_ready is 1 throughout IDLE, so req_valid alone means accept
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cs    <= 1'b1;
            r_ready <= 1'b0;
            if (req_we) begin
              r_state <= WR;
              r_we    <= 1'b1;
              r_oe    <= 1'b0;
              r_drive <= 1'b1;
            end else begin
              r_state <= RD_ADDR;
              r_we    <= 1'b0;
              r_oe    <= 1'b1;
              r_drive <= 1'b0;
            end
          end
        end
        WR: begin
          r_state <= IDLE;
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_drive <= 1'b0;
          r_ready <= 1'b1;
        end
        RD_ADDR: begin
          r_state <= RD_DATA;
        end
        RD_DATA: begin
          // RAM drives its registered word for the whole of this cycle
          r_state     <= IDLE;
          r_rsp_rdata <= ram_data;
          r_rsp_valid <= 1'b1;
          r_cs        <= 1'b0;
          r_oe        <= 1'b0;
          r_ready     <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_oe    <= 1'b0;
          r_drive <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign ram_addr  = r_addr;
  assign ram_cs    = r_cs;
  assign ram_we    = r_we;
  assign ram_oe    = r_oe;
  assign ram_data  = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_port_master.sv
// Scoreboard bench: sram_port_master wired straight to single_port_sync_ram.
module tb_sram_port_master;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;
  wire  [DW-1:0] ram_data;

  always #5 clk = ~clk;

  sram_port_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
  );

  single_port_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
    .clk(clk), .addr(ram_addr), .data(ram_data),
    .cs(ram_cs), .we(ram_we), .oe(ram_oe)
  );

  typedef struct {
    logic [DW-1:0] data;
    bit            chk;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            acc_cnt = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) acc_cnt++;
  end

  // Monitor: bus protocol checks every cycle, response checks on rsp_valid.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      check("no_we_oe_overlap", 64'(ram_we & ram_oe), 64'd0);
      if (ram_cs) check("ready_low_busy", 64'(req_ready), 64'd0);
      if (ram_cs && ram_we) begin
        check("wr_addr", 64'(ram_addr), 64'(exp_addr));
        check("wr_data", 64'(ram_data), 64'(exp_wdata));
      end
      if (ram_cs && ram_oe) check("rd_addr", 64'(ram_addr), 64'(exp_addr));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp_valid", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_latency", 64'(cyc), 64'(e.due));
          if (e.chk) check("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
        end
      end
    end
  end

  // Leaves req_valid high on return so callers can chain back-to-back requests.
  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit chk, input logic [DW-1:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      req_we    = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = $urandom;
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      check("ready_timeout", 64'd0, 64'd1);
    end else begin
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      exp_addr  = a;
      exp_wdata = d;
      if (!we) sb.push_back('{data: exp, chk: chk, due: cyc + 3});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"},  64'(req_ready), 64'd1);
    check({tag, "_rspv"},   64'(rsp_valid), 64'd0);
    check({tag, "_rdata"},  64'(rsp_rdata), 64'd0);
    check({tag, "_ctl"},    64'({ram_cs, ram_we, ram_oe}), 64'd0);
    check({tag, "_addr"},   64'(ram_addr), 64'd0);
  endtask

  initial begin
    int acc0;
    // Reset with a pending write request that must be ignored.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'd3;
    req_wdata = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_no_accept", 64'(acc_cnt), 64'd0);
    req_valid = 1'b0;
    rst = 1'b0;

    // Uninitialised read: only presence and latency matter.
    issue(1'b0, 4'd5, '0, 1'b0, '0);
    idle();

    issue(1'b1, 4'd2, 32'hABCDE123, 1'b0, '0);
    issue(1'b0, 4'd2, '0, 1'b1, 32'hABCDE123);
    idle();

    issue(1'b1, 4'd0,  32'h11111111, 1'b0, '0);
    idle();
    issue(1'b1, 4'd15, 32'hFFFF0000, 1'b0, '0);
    idle();
    issue(1'b0, 4'd15, '0, 1'b1, 32'hFFFF0000);
    idle();
    issue(1'b0, 4'd0,  '0, 1'b1, 32'h11111111);
    idle();

    // Back-to-back with req_valid held; inputs scrambled while busy.
    repeat (3) @(negedge clk);
    acc0 = acc_cnt;
    issue(1'b1, 4'd7, 32'hA5A5A5A5, 1'b0, '0);
    issue(1'b0, 4'd7, '0, 1'b1, 32'hA5A5A5A5);
    issue(1'b1, 4'd8, 32'h5A5A5A5A, 1'b0, '0);
    idle();
    check("b2b_accepts", 64'(acc_cnt - acc0), 64'd3);
    issue(1'b0, 4'd8, '0, 1'b1, 32'h5A5A5A5A);
    idle();
    repeat (4) @(negedge clk);

    // Reset while in RD_ADDR aborts the read.
    issue(1'b0, 4'd2, '0, 1'b0, '0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check_quiet("abort");
    repeat (5) @(negedge clk);

    issue(1'b0, 4'd2, '0, 1'b1, 32'hABCDE123);
    idle();

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
